// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore-style sequencer for a shared-memory multi-cycle RV32 subset
//   datapath. Walks FETCH / DECODE / execute phases and drives the datapath
//   enables for the current phase. It stalls on mem_ready during memory
//   phases, traps unsupported opcodes, and counts retired instructions.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   opcode             instr[6:0] from the IR, looked at in DECODE only
//   mem_ready          memory finishes the current access this cycle
//   PCWrite/IRWrite    PC and IR load strobes; only high in FETCH with mem_ready
//   PCWriteCond        PC load qualified by ALU zero (branch)
//   IorD               memory address select (0 PC, 1 ALUOut)
//   MemRead/MemWrite   memory request strobes
//   MemtoReg/RegWrite  register-file write data select and write enable
//   ALUSrcA/ALUSrcB    ALU operand selects
//   ALUOp              ALU-control selector (00 add, 01 sub, 10 R, 11 I)
//   PCSource           PC source (0 ALU result, 1 ALUOut)
//   illegal            one-cycle pulse while in TRAP
//   state              current state encoding (debug)
//   retired            retired-instruction count, wraps
//
// state      | meaning
// -----------+--------------------------------------------------
// RST    0   | post-reset idle, all outputs low
// FETCH  1   | read instruction at PC, PC+4 computed in parallel
// DECODE 2   | branch target precomputed into ALUOut, opcode examined
// MEM_ADDR 3 | effective address rs1 + imm
// MEM_READ 4 | load access, held until mem_ready
// MEM_WB 5   | MDR written to register file
// MEM_WRITE 6| store access, held until mem_ready
// EXEC 7     | R-type or I-type ALU operation
// ALU_WB 8   | ALUOut written to register file
// BRANCH 9   | compare rs1/rs2, conditional PC load from ALUOut
// TRAP 10    | unsupported opcode, illegal pulse

module multicycle_control #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter int EN_ITYPE = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                PCSource,
  output logic                illegal,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC      = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd10
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_R   = ALUOP_W'(2'b10);
  localparam logic [ALUOP_W-1:0] ALU_I   = ALUOP_W'(2'b11);

  state_t             state_q, state_d;
  logic               is_itype_q, is_itype_d;
  logic               is_store_q, is_store_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic               pc_write_cond_q, pc_write_cond_d;
  logic               iord_q, iord_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic               memto_reg_q, memto_reg_d;
  logic               reg_write_q, reg_write_d;
  logic               alu_src_a_q, alu_src_a_d;
  logic [1:0]         alu_src_b_q, alu_src_b_d;
  logic [ALUOP_W-1:0] alu_op_q, alu_op_d;
  logic               pc_source_q, pc_source_d;
  logic               illegal_q, illegal_d;

  // Next state, decode latches and retirement.
  always_comb begin
    state_d    = state_q;
    is_itype_d = is_itype_q;
    is_store_d = is_store_q;
    retired_d  = retired_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        is_itype_d = (opcode == OP_ITYPE);
        // The store/load split is remembered here so MEM_ADDR does not
        // depend on the opcode input after DECODE.
        is_store_d = (opcode == OP_STORE);
        if (opcode == OP_LOAD || opcode == OP_STORE)
          state_d = S_MEM_ADDR;
        else if (opcode == OP_RTYPE)
          state_d = S_EXEC;
        else if (opcode == OP_ITYPE && EN_ITYPE != 0)
          state_d = S_EXEC;
        else if (opcode == OP_BRANCH)
          state_d = S_BRANCH;
        else
          state_d = S_TRAP;
      end
      S_MEM_ADDR: state_d = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      S_MEM_WRITE: begin
        if (mem_ready) begin
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      S_EXEC: state_d = S_ALU_WB;
      S_ALU_WB, S_BRANCH: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      S_TRAP:  state_d = S_FETCH;
      default: state_d = S_RST;
    endcase
  end

  // Moore outputs are decoded from the next state so they appear registered
  // in the same cycle as the state they belong to. EXEC uses the itype flag
  // being latched on the DECODE->EXEC edge, hence is_itype_d.
  always_comb begin
    pc_write_cond_d = 1'b0;
    iord_d          = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    memto_reg_d     = 1'b0;
    reg_write_d     = 1'b0;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    alu_op_d        = ALU_ADD;
    pc_source_d     = 1'b0;
    illegal_d       = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_read_d  = 1'b1;
        alu_src_b_d = 2'b01;
      end
      S_DECODE: alu_src_b_d = 2'b10;
      S_MEM_ADDR: begin
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'b10;
      end
      S_MEM_READ: begin
        mem_read_d = 1'b1;
        iord_d     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_d = 1'b1;
        memto_reg_d = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write_d = 1'b1;
        iord_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a_d = 1'b1;
        if (is_itype_d) begin
          alu_src_b_d = 2'b10;
          alu_op_d    = ALU_I;
        end else begin
          alu_src_b_d = 2'b00;
          alu_op_d    = ALU_R;
        end
      end
      S_ALU_WB: reg_write_d = 1'b1;
      S_BRANCH: begin
        alu_src_a_d     = 1'b1;
        alu_op_d        = ALU_SUB;
        pc_write_cond_d = 1'b1;
        pc_source_d     = 1'b1;
      end
      S_TRAP:  illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_RST;
      is_itype_q      <= 1'b0;
      is_store_q      <= 1'b0;
      retired_q       <= '0;
      pc_write_cond_q <= 1'b0;
      iord_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      memto_reg_q     <= 1'b0;
      reg_write_q     <= 1'b0;
      alu_src_a_q     <= 1'b0;
      alu_src_b_q     <= 2'b00;
      alu_op_q        <= '0;
      pc_source_q     <= 1'b0;
      illegal_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_itype_q      <= is_itype_d;
      is_store_q      <= is_store_d;
      retired_q       <= retired_d;
      pc_write_cond_q <= pc_write_cond_d;
      iord_q          <= iord_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      memto_reg_q     <= memto_reg_d;
      reg_write_q     <= reg_write_d;
      alu_src_a_q     <= alu_src_a_d;
      alu_src_b_q     <= alu_src_b_d;
      alu_op_q        <= alu_op_d;
      pc_source_q     <= pc_source_d;
      illegal_q       <= illegal_d;
    end
  end

  // IR and PC load track mem_ready directly so the instruction is captured
  // in the very cycle memory delivers it.
  assign IRWrite     = (state_q == S_FETCH) && mem_ready;
  assign PCWrite     = (state_q == S_FETCH) && mem_ready;
  assign PCWriteCond = pc_write_cond_q;
  assign IorD        = iord_q;
  assign MemRead     = mem_read_q;
  assign MemWrite    = mem_write_q;
  assign MemtoReg    = memto_reg_q;
  assign RegWrite    = reg_write_q;
  assign ALUSrcA     = alu_src_a_q;
  assign ALUSrcB     = alu_src_b_q;
  assign ALUOp       = alu_op_q;
  assign PCSource    = pc_source_q;
  assign illegal     = illegal_q;
  assign state       = state_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: random instruction stream with random memory
// stalls and occasional resets against a per-instruction phase-plan model,
// plus a short directed run on a second instance with I-type disabled.
module tb_multicycle_control;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: EN_ITYPE=1, 4-bit retired counter (exercises wrap).
  logic       reset, mem_ready;
  logic [6:0] opcode;
  logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rw, a_asa;
  logic [1:0] a_asb, a_aop;
  logic       a_pcs, a_ill;
  logic [3:0] a_state;
  logic [3:0] a_ret;

  multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .EN_ITYPE(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(a_pcw), .PCWriteCond(a_pcwc), .IorD(a_iord), .MemRead(a_mrd),
    .MemWrite(a_mwr), .IRWrite(a_irw), .MemtoReg(a_m2r), .RegWrite(a_rw),
    .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_aop), .PCSource(a_pcs),
    .illegal(a_ill), .state(a_state), .retired(a_ret)
  );

  // Instance B: EN_ITYPE=0, default 32-bit counter.
  logic        reset_b, mr_b;
  logic [6:0]  opcode_b;
  logic        b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rw, b_asa;
  logic [1:0]  b_asb, b_aop;
  logic        b_pcs, b_ill;
  logic [3:0]  b_state;
  logic [31:0] b_ret;

  multicycle_control #(.OPCODE_W(7), .ALUOP_W(2), .EN_ITYPE(0), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset_b), .opcode(opcode_b), .mem_ready(mr_b),
    .PCWrite(b_pcw), .PCWriteCond(b_pcwc), .IorD(b_iord), .MemRead(b_mrd),
    .MemWrite(b_mwr), .IRWrite(b_irw), .MemtoReg(b_m2r), .RegWrite(b_rw),
    .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aop), .PCSource(b_pcs),
    .illegal(b_ill), .state(b_state), .retired(b_ret)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected enables for a phase, straight from the phase descriptions.
  // Packing: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  //           RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource,illegal}
  function automatic logic [14:0] exp_outs(int s, bit itype, bit mr);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
    logic m2r = 0, rw = 0, asa = 0, pcs = 0, ill = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00;
    case (s)
      1:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
      2:  asb = 2'b10;
      3:  begin asa = 1; asb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iord = 1; end
      7:  begin asa = 1; if (itype) begin asb = 2'b10; aop = 2'b11; end else aop = 2'b10; end
      8:  rw = 1;
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 1; end
      10: ill = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, asa, asb, aop, pcs, ill};
  endfunction

  // Reference model: the remaining phases of the current instruction.
  int         plan[$];
  bit         op_set;
  bit         itype_m;
  int         ret_m;
  bit         did_mr_rst;
  logic [6:0] ops[7] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h7F, 7'h00};

  initial begin
    int s;
    logic [6:0]  op;
    logic [14:0] obs;
    int b_exp[8] = '{0, 1, 2, 10, 1, 2, 9, 1};

    reset = 1'b1; mem_ready = 1'b0; opcode = 7'h00;
    reset_b = 1'b1; mr_b = 1'b1; opcode_b = 7'h00;
    repeat (2) @(posedge clk);
    plan = {0}; op_set = 0; itype_m = 0; ret_m = 0; did_mr_rst = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      s = plan[0];
      if (s == 1 && !op_set) begin
        op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
        opcode  = op;
        itype_m = (op == 7'h13);
        op_set  = 1;
        case (op)
          7'h03:        begin plan.push_back(2); plan.push_back(3); plan.push_back(4); plan.push_back(5); end
          7'h23:        begin plan.push_back(2); plan.push_back(3); plan.push_back(6); end
          7'h33, 7'h13: begin plan.push_back(2); plan.push_back(7); plan.push_back(8); end
          7'h63:        begin plan.push_back(2); plan.push_back(9); end
          default:      begin plan.push_back(2); plan.push_back(10); end
        endcase
      end
      mem_ready = ($urandom_range(0, 99) < 65);
      if (s == 4 && !did_mr_rst && cyc > 100) begin
        reset = 1'b1;
        did_mr_rst = 1;
      end else begin
        reset = ($urandom_range(0, 199) == 0);
      end
      #1;
      obs = {a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rw, a_asa, a_asb, a_aop, a_pcs, a_ill};
      chk($sformatf("c%0d state", cyc), {28'b0, a_state}, s);
      chk($sformatf("c%0d outs s%0d", cyc, s), {17'b0, obs}, {17'b0, exp_outs(s, itype_m, mem_ready)});
      chk($sformatf("c%0d retired", cyc), {28'b0, a_ret}, ret_m % 16);

      @(posedge clk);
      if (reset) begin
        plan = {0}; ret_m = 0; op_set = 0;
      end else if ((s == 1 || s == 4 || s == 6) && !mem_ready) begin
        // stalled: phase unchanged
      end else begin
        if (s == 5 || s == 6 || s == 8 || s == 9) ret_m++;
        void'(plan.pop_front());
        if (plan.size() == 0) begin
          plan.push_back(1);
          op_set = 0;
        end
      end
    end

    // Instance B: I-type opcode must trap, then a branch must retire.
    @(negedge clk);
    reset = 1'b1;
    reset_b = 1'b0; opcode_b = 7'h13; mr_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("b%0d state", i), {28'b0, b_state}, b_exp[i]);
      chk($sformatf("b%0d illegal", i), {31'b0, b_ill}, (b_exp[i] == 10) ? 1 : 0);
      chk($sformatf("b%0d retired", i), b_ret, (i == 7) ? 1 : 0);
      if (i == 4) opcode_b = 7'h63;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
